// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide CPU bus responder with a RAM region and a small
// IO page (UART-style RX/TX byte streams, halt register, cycle counter).
//
// Optional build macro: RESPONDER_CYCLE_COUNTER_EN
//   defined   -> free-running 32-bit cycle counter with a read snapshot at
//                0x30004..0x30007
//   undefined -> counter and snapshot absent, 0x30004..0x30007 read as 0x00
//
// IO map (a_in[17:16] == 2'b11, offset = a_in[15:0]):
//   0x0000 read : RX byte (0x00 when rx_valid is low), pops the RX source
//   0x0000 write: push d_in into the TX FIFO (0x00 is ignored)
//   0x0004 write: push 0x00 into the TX FIFO and set halt
//   0x0004 read : snapshot the cycle counter, return byte 0
//   0x0005-7    : snapshot bytes 1..3
//
// Handshakes: rx and tx are valid/ready streams. A byte moves on a clock edge
// exactly when valid and ready are both high at that edge; valid never depends
// on ready, and the producer holds data stable while valid is high and ready
// is low.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH_LOG2  = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en_in,
  input  logic [31:0] a_in,
  input  logic        wr_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        io_buffer_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic        tx_overflow
);

  localparam int DEPTH = 1 << TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] DEPTH_C  = (TX_DEPTH_LOG2 + 1)'(DEPTH);
  // Two entries of slack so the CPU can still land in-flight writes after
  // it sees io_buffer_full.
  localparam logic [TX_DEPTH_LOG2:0] FULL_THR = (TX_DEPTH_LOG2 + 1)'(DEPTH - 2);

  // ---------------- address decode ----------------
  logic        is_io;
  logic [15:0] io_off;
  logic        sel_rxtx;
  logic        sel_halt;
  logic        rd_cyc;
  logic        wr_cyc;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic        unused_addr;

  assign is_io       = (a_in[17:16] == 2'b11);
  assign io_off      = a_in[15:0];
  assign sel_rxtx    = is_io && (io_off == 16'h0000);
  assign sel_halt    = is_io && (io_off == 16'h0004);
  assign ram_addr    = a_in[RAM_ADDR_WIDTH-1:0];
  assign unused_addr = ^a_in[31:18];

  // Every enabled cycle is an access; once halted, writes are dropped.
  assign rd_cyc = en_in && !wr_in;
  assign wr_cyc = en_in && wr_in && !halt;

  // RX pop is combinational so the byte consumed is the byte returned.
  assign rx_ready = !rst_in && rd_cyc && !halt && sel_rxtx && rx_valid;

  // ---------------- RAM ----------------
  logic [7:0] ram [0:(1 << RAM_ADDR_WIDTH) - 1];

  // RAM write port; contents are deliberately untouched by reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in && wr_cyc && !is_io) begin
      ram[ram_addr] <= d_in;
    end
  end

  // ---------------- cycle counter ----------------
`ifdef RESPONDER_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;
  logic [31:0] cnt_snap;
  logic        sel_cnt;

  assign sel_cnt = is_io && (io_off[15:2] == 14'h0001);

  // Counter runs while enabled and not halted; a read of byte 0 freezes a
  // snapshot so the upper bytes read later are from the same instant.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt <= 32'h0;
      cnt_snap  <= 32'h0;
    end else if (en_in) begin
      if (!halt) begin
        cycle_cnt <= cycle_cnt + 32'h1;
      end
      if (rd_cyc && sel_cnt && (io_off[1:0] == 2'b00)) begin
        cnt_snap <= cycle_cnt;
      end
    end
  end
`endif

  // ---------------- read mux ----------------
  logic [7:0] rd_data;

  // Select the byte that d_out captures at the read edge.
  always_comb begin
    rd_data = 8'h00;
    if (!is_io) begin
      rd_data = ram[ram_addr];
    end else if (sel_rxtx) begin
      rd_data = rx_valid ? rx_data : 8'h00;
    end
`ifdef RESPONDER_CYCLE_COUNTER_EN
    else if (sel_cnt) begin
      case (io_off[1:0])
        2'd0:    rd_data = cycle_cnt[7:0];
        2'd1:    rd_data = cnt_snap[15:8];
        2'd2:    rd_data = cnt_snap[23:16];
        default: rd_data = cnt_snap[31:24];
      endcase
    end
`endif
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]               fifo_mem [DEPTH];
  logic [TX_DEPTH_LOG2-1:0] wr_ptr;
  logic [TX_DEPTH_LOG2-1:0] rd_ptr;
  logic [TX_DEPTH_LOG2:0]   count;
  logic [TX_DEPTH_LOG2:0]   count_nxt;
  logic                     push_req;
  logic                     push_ok;
  logic                     pop;
  logic [7:0]               push_data;

  assign push_req  = wr_cyc && ((sel_rxtx && (d_in != 8'h00)) || sel_halt);
  assign push_data = sel_halt ? 8'h00 : d_in;
  // tx_valid is gated by en_in so a frozen FIFO never offers a byte it
  // cannot retire.
  assign tx_valid  = en_in && (count != '0);
  assign tx_data   = fifo_mem[rd_ptr];
  assign pop       = tx_valid && tx_ready;
  // A full FIFO can still take a byte when its head leaves on the same edge.
  assign push_ok   = push_req && ((count < DEPTH_C) || pop);

  // Occupancy after this edge.
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // FIFO storage write port (data only, no reset needed).
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_ok) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // Control state: read data, FIFO pointers, sticky flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      d_out          <= 8'h00;
      io_buffer_full <= 1'b0;
      halt           <= 1'b0;
      tx_overflow    <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else if (en_in) begin
      if (rd_cyc) begin
        d_out <= rd_data;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count          <= count_nxt;
      io_buffer_full <= (count_nxt >= FULL_THR);
      if (push_req && !push_ok) begin
        tx_overflow <= 1'b1;
      end
      if (wr_cyc && sel_halt) begin
        halt <= 1'b1;
      end
    end
  end

endmodule
